// File: rtl/cc_miss_fill_ctrl_pkg.sv
// Shared widths, AXI constants and fill FSM state type for the cache miss-fill path.
package cc_pkg;

    localparam int unsigned TAG_W  = 17;
    localparam int unsigned IDX_W  = 9;
    localparam int unsigned OFF_W  = 6;
    localparam int unsigned LINE_W = 512;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] SIZE_8B    = 3'b011;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RECV,
        WRITE,
        DONE
    } fill_state_t;

endpackage

// File: rtl/cc_miss_fill_ctrl_if.sv
// AXI read-address / read-data channel bundle between the fill controller and memory.
interface cc_miss_fill_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    logic [ADDR_W-1:0] araddr_o;
    logic [3:0]        arlen_o;
    logic [2:0]        arsize_o;
    logic [1:0]        arburst_o;
    logic              arvalid_o;
    logic              arready_i;
    logic [DATA_W-1:0] rdata_i;
    logic [1:0]        rresp_i;
    logic              rlast_i;
    logic              rvalid_i;
    logic              rready_o;

    modport master (
        output araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o, rready_o,
        input  arready_i, rdata_i, rresp_i, rlast_i, rvalid_i
    );

    modport slave (
        input  araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o, rready_o,
        output arready_i, rdata_i, rresp_i, rlast_i, rvalid_i
    );
endinterface

// File: rtl/cc_miss_fill_ctrl_line_assembler.sv
// Beat counter and line buffer: drops each accepted R beat into its slot and accumulates errors.
module cc_line_assembler
    import cc_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned BEATS  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_beat,
    input  logic [DATA_W-1:0]       i_rdata,
    input  logic [1:0]              i_rresp,
    input  logic                    i_rlast,
    output logic [BEATS*DATA_W-1:0] o_line,
    output logic                    o_last,
    output logic                    o_err,
    output logic                    o_err_nxt
);
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]        r_cnt;
    logic                    r_err;
    logic [BEATS*DATA_W-1:0] r_line;
    logic                    w_cnt_last;
    logic                    w_beat_err;

    // The counter decides the end of the burst; an early rlast ends it too but is an error.
    always_comb begin
        w_cnt_last = (r_cnt == LAST_CNT);
        w_beat_err = (i_rresp != RESP_OKAY) || (i_rlast && !w_cnt_last);
        o_last     = i_beat && (i_rlast || w_cnt_last);
        o_err_nxt  = r_err || (i_beat && w_beat_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_err  <= 1'b0;
            r_line <= '0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else if (i_beat) begin
            r_line[int'(r_cnt)*DATA_W +: DATA_W] <= i_rdata;
            r_err  <= o_err_nxt;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign o_line = r_line;
    assign o_err  = r_err;

endmodule

// File: rtl/cc_miss_fill_ctrl.sv
// Cache miss fill: one AXI INCR burst per missing line, then data+tag SRAM write and a done pulse.
module cc_miss_fill_ctrl
    import cc_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned BEATS  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    miss_i,
    input  logic [TAG_W-1:0]        tag_i,
    input  logic [IDX_W-1:0]        index_i,
    input  logic [OFF_W-1:0]        offset_i,
    output logic                    busy_o,
    cc_miss_fill_ctrl_if.master     axi,
    output logic                    data_wren_o,
    output logic [IDX_W-1:0]        data_windex_o,
    output logic [BEATS*DATA_W-1:0] data_wdata_o,
    output logic                    tag_wren_o,
    output logic [IDX_W-1:0]        tag_windex_o,
    output logic [TAG_W:0]          tag_wdata_o,
    output logic                    fill_done_o,
    output logic [OFF_W-1:0]        fill_offset_o,
    output logic                    fill_err_o
);
    fill_state_t       r_state;
    logic [TAG_W-1:0]  r_tag;
    logic [IDX_W-1:0]  r_index;
    logic [OFF_W-1:0]  r_offset;
    logic [ADDR_W-1:0] r_araddr;
    logic              r_arvalid;
    logic              r_rready;
    logic              r_busy;
    logic              r_wren;
    logic [TAG_W:0]    r_tag_wdata;
    logic              r_done;
    logic              r_err_out;

    logic              w_capture;
    logic              w_beat;
    logic              w_last;
    logic              w_err;
    logic              w_err_nxt;

    assign w_capture = (r_state == IDLE) && miss_i;
    assign w_beat    = (r_state == RECV) && axi.rvalid_i;

    cc_line_assembler #(
        .DATA_W (DATA_W),
        .BEATS  (BEATS)
    ) u_asm (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_capture),
        .i_beat    (w_beat),
        .i_rdata   (axi.rdata_i),
        .i_rresp   (axi.rresp_i),
        .i_rlast   (axi.rlast_i),
        .o_line    (data_wdata_o),
        .o_last    (w_last),
        .o_err     (w_err),
        .o_err_nxt (w_err_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_tag       <= '0;
            r_index     <= '0;
            r_offset    <= '0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_busy      <= 1'b0;
            r_wren      <= 1'b0;
            r_tag_wdata <= '0;
            r_done      <= 1'b0;
            r_err_out   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (miss_i) begin
                        r_tag     <= tag_i;
                        r_index   <= index_i;
                        r_offset  <= offset_i;
                        r_araddr  <= ADDR_W'({tag_i, index_i, {OFF_W{1'b0}}});
                        r_arvalid <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= REQ;
                    end
                end
                REQ: begin
                    if (axi.arready_i) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RECV;
                    end
                end
                RECV: begin
                    // Error flag must include the final beat, so take the assembler's next value.
                    if (w_last) begin
                        r_rready    <= 1'b0;
                        r_wren      <= 1'b1;
                        r_tag_wdata <= {~w_err_nxt, r_tag};
                        r_state     <= WRITE;
                    end
                end
                WRITE: begin
                    r_wren    <= 1'b0;
                    r_done    <= 1'b1;
                    r_err_out <= w_err;
                    r_busy    <= 1'b0;
                    r_state   <= DONE;
                end
                DONE: begin
                    r_done    <= 1'b0;
                    r_err_out <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy_o        = r_busy;
    assign axi.araddr_o  = r_araddr;
    assign axi.arlen_o   = 4'(BEATS - 1);
    assign axi.arsize_o  = SIZE_8B;
    assign axi.arburst_o = BURST_INCR;
    assign axi.arvalid_o = r_arvalid;
    assign axi.rready_o  = r_rready;
    assign data_wren_o   = r_wren;
    assign data_windex_o = r_index;
    assign tag_wren_o    = r_wren;
    assign tag_windex_o  = r_index;
    assign tag_wdata_o   = r_tag_wdata;
    assign fill_done_o   = r_done;
    assign fill_offset_o = r_offset;
    assign fill_err_o    = r_err_out;

endmodule

// File: tb/tb_cc_miss_fill_ctrl.sv
// Scoreboard bench for cc_miss_fill_ctrl: an AXI slave drives bursts, a monitor checks SRAM writes and done pulses.
module tb_cc_miss_fill_ctrl;
    import cc_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          miss_i;
    logic [16:0]   tag_i;
    logic [8:0]    index_i;
    logic [5:0]    offset_i;
    logic          busy_o;
    logic          data_wren_o;
    logic [8:0]    data_windex_o;
    logic [511:0]  data_wdata_o;
    logic          tag_wren_o;
    logic [8:0]    tag_windex_o;
    logic [17:0]   tag_wdata_o;
    logic          fill_done_o;
    logic [5:0]    fill_offset_o;
    logic          fill_err_o;

    cc_miss_fill_ctrl_if axi ();

    cc_miss_fill_ctrl #(.ADDR_W(32), .DATA_W(64), .BEATS(8)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .miss_i        (miss_i),
        .tag_i         (tag_i),
        .index_i       (index_i),
        .offset_i      (offset_i),
        .busy_o        (busy_o),
        .axi           (axi),
        .data_wren_o   (data_wren_o),
        .data_windex_o (data_windex_o),
        .data_wdata_o  (data_wdata_o),
        .tag_wren_o    (tag_wren_o),
        .tag_windex_o  (tag_windex_o),
        .tag_wdata_o   (tag_wdata_o),
        .fill_done_o   (fill_done_o),
        .fill_offset_o (fill_offset_o),
        .fill_err_o    (fill_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]   idx;
        logic [17:0]  tagw;
        logic [511:0] line;
        logic [5:0]   off;
        logic         err;
        int           lat;
        int           miss_cyc;
    } exp_t;

    exp_t         sb[$];
    logic [511:0] mline = '0;
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           ar_cnt = 0;
    int           wren_cnt = 0;
    int           done_cnt = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (axi.arvalid_o && axi.arready_i) ar_cnt++;
        if (data_wren_o) begin
            wren_cnt++;
            if (sb.size() == 0) chk("unexpected_wren", 1'b1, 1'b0);
            else begin
                chk("line", data_wdata_o, sb[0].line);
                chk("data_windex", data_windex_o, sb[0].idx);
                chk("tag_wren", tag_wren_o, 1'b1);
                chk("tag_windex", tag_windex_o, sb[0].idx);
                chk("tag_wdata", tag_wdata_o, sb[0].tagw);
            end
        end
        if (fill_done_o) begin
            done_cnt++;
            if (sb.size() == 0) chk("unexpected_done", 1'b1, 1'b0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("fill_offset", fill_offset_o, e.off);
                chk("fill_err", fill_err_o, e.err);
                // The miss_i cycle itself counts as cycle 1.
                chk("latency", cyc - e.miss_cyc + 1, e.lat);
                chk("busy_in_done", busy_o, 1'b0);
            end
        end
    end

    // nb = last_beat+1 beats are sent; rst_beat<8 aborts the fill with rst on that beat.
    task automatic do_fill(input logic [16:0] t, input logic [8:0] ix, input logic [5:0] of,
                           input logic [63:0] base, input int ar_wait, input bit gaps,
                           input int err_beat, input int last_beat, input int rst_beat, input bit remiss);
        exp_t         e;
        logic [511:0] eline;
        logic [31:0]  exp_addr;
        int           nb;
        int           a0;
        int           d0;
        int           w0;
        bit           aborted;
        nb       = last_beat + 1;
        eline    = mline;
        exp_addr = {t, ix, 6'b0};
        for (int b = 0; b < nb; b++) eline[b*64 +: 64] = base + 64'(b);
        e.idx  = ix;
        e.err  = (err_beat < nb) || (last_beat != 7);
        e.tagw = {~e.err, t};
        e.line = eline;
        e.off  = of;
        e.lat  = 4 + nb + ar_wait + (gaps ? nb : 0);
        a0 = ar_cnt; d0 = done_cnt; w0 = wren_cnt;
        aborted = 1'b0;

        @(posedge clk); #1;
        miss_i = 1'b1; tag_i = t; index_i = ix; offset_i = of;
        e.miss_cyc = cyc;
        if (rst_beat >= 8) sb.push_back(e);
        @(posedge clk); #1;
        miss_i = 1'b0;
        chk("busy_after_miss", busy_o, 1'b1);

        for (int w = 0; w <= ar_wait; w++) begin
            chk("arvalid", axi.arvalid_o, 1'b1);
            chk("araddr", axi.araddr_o, exp_addr);
            chk("rready_in_req", axi.rready_o, 1'b0);
            axi.arready_i = (w == ar_wait);
            if (remiss && w == 0) begin
                miss_i = 1'b1; tag_i = t ^ 17'h1; index_i = ix + 9'd1;
            end
            @(posedge clk); #1;
            miss_i = 1'b0;
        end
        axi.arready_i = 1'b0;

        for (int b = 0; b < nb; b++) begin
            if (gaps) begin
                axi.rvalid_i = 1'b0;
                @(posedge clk); #1;
            end
            chk("rready_in_recv", axi.rready_o, 1'b1);
            axi.rvalid_i = 1'b1;
            axi.rdata_i  = base + 64'(b);
            axi.rresp_i  = (b == err_beat) ? 2'b10 : RESP_OKAY;
            axi.rlast_i  = (b == last_beat);
            if (b == rst_beat) rst = 1'b1;
            @(posedge clk); #1;
            if (b == rst_beat) begin
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
        end
        axi.rvalid_i = 1'b0; axi.rlast_i = 1'b0; axi.rresp_i = RESP_OKAY;

        if (aborted) begin
            mline = '0;
            chk("rst_busy", busy_o, 1'b0);
            chk("rst_arvalid", axi.arvalid_o, 1'b0);
            chk("rst_rready", axi.rready_o, 1'b0);
            for (int s = 0; s < 3; s++) begin
                axi.rvalid_i = 1'b1;
                axi.rdata_i  = 64'hDEAD_0000_0000_0000 + 64'(s);
                axi.rlast_i  = (s == 2);
                chk("stray_rready", axi.rready_o, 1'b0);
                @(posedge clk); #1;
            end
            axi.rvalid_i = 1'b0; axi.rlast_i = 1'b0;
            repeat (12) @(posedge clk);
            #1;
            chk("rst_no_wren", wren_cnt - w0, 0);
            chk("rst_no_done", done_cnt - d0, 0);
        end else begin
            mline = eline;
            for (int k = 0; k < 40 && done_cnt == d0; k++) @(posedge clk);
            #1;
            chk("done_seen", done_cnt - d0, 1);
            chk("one_wren", wren_cnt - w0, 1);
        end
        chk("one_ar", ar_cnt - a0, 1);
        chk("sb_empty", sb.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; miss_i = 1'b0; tag_i = '0; index_i = '0; offset_i = '0;
        axi.arready_i = 1'b0; axi.rdata_i = '0; axi.rresp_i = RESP_OKAY;
        axi.rlast_i = 1'b0; axi.rvalid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy0", busy_o, 1'b0);
        chk("rst_arvalid0", axi.arvalid_o, 1'b0);
        chk("rst_rready0", axi.rready_o, 1'b0);
        chk("rst_wren0", data_wren_o, 1'b0);
        chk("rst_done0", fill_done_o, 1'b0);
        chk("rst_araddr0", axi.araddr_o, 32'h0);
        chk("rst_line0", data_wdata_o, 512'h0);
        chk("rst_tagw0", tag_wdata_o, 18'h0);
        chk("arlen", axi.arlen_o, 4'd7);
        chk("arsize", axi.arsize_o, 3'b011);
        chk("arburst", axi.arburst_o, 2'b01);
        rst = 1'b0;

        // tag, index, offset, base, ar_wait, gaps, err_beat, last_beat, rst_beat, remiss
        do_fill(17'h1ABCD, 9'h005, 6'h18, 64'h0,                   0, 1'b0, 99, 7, 99, 1'b0);
        do_fill(17'h00F0F, 9'h1FF, 6'h3F, 64'h1111_2222_0000_0000, 5, 1'b0, 99, 7, 99, 1'b0);
        do_fill(17'h1ABCD, 9'h005, 6'h18, 64'h0,                   0, 1'b1, 99, 7, 99, 1'b0);
        do_fill(17'h0AAAA, 9'h100, 6'h01, 64'h3333_0000_0000_0000, 0, 1'b0,  3, 7, 99, 1'b0);
        do_fill(17'h15555, 9'h0AA, 6'h20, 64'h4444_0000_0000_0000, 1, 1'b0, 99, 4, 99, 1'b0);
        do_fill(17'h12345, 9'h033, 6'h07, 64'h5555_0000_0000_0000, 3, 1'b0, 99, 7, 99, 1'b1);
        do_fill(17'h0BEEF, 9'h044, 6'h10, 64'h6666_0000_0000_0000, 0, 1'b0, 99, 7,  3, 1'b0);
        do_fill(17'h1FFFF, 9'h000, 6'h00, 64'h7777_0000_0000_0000, 0, 1'b0, 99, 2, 99, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
